// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//
// Frame-level controller for the pixel pipeline.
// - Walks the raster one pixel beat at a time and presents the coordinates
//   with valid/sof/eol/eof.
// - Honours downstream back-pressure: valid is never withdrawn while a beat
//   waits.
// - Inserts HBLANK idle cycles between lines.
// - Closes each frame with a single FRAME_END cycle.
// - Rotates the pipeline phase every PHASE_FRAMES completed frames.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   start        level; begins streaming when seen high while idle
//   stop         request to halt once the current frame has completed
//   ready        pipeline accepts a beat this cycle
//   valid        beat presented (x, y and markers meaningful)
//   x, y         raster coordinates of the presented beat
//   sof/eol/eof  start-of-frame / end-of-line / end-of-frame markers
//   phase        0=INIT, 1=CREATE_EDGE, 2=ADD_NOISE
//   busy         controller is not idle
//   frame_count  completed frames since reset, wraps modulo 2^FCW
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int WIDTH        = 8,
  parameter int HEIGHT       = 4,
  parameter int HBLANK       = 2,
  parameter int PHASE_FRAMES = 1,
  parameter int FCW          = 16,
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic           stop,
  input  logic           ready,
  output logic           valid,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic           sof,
  output logic           eol,
  output logic           eof,
  output logic [1:0]     phase,
  output logic           busy,
  output logic [FCW-1:0] frame_count
);

  localparam int HCW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam int PFW = (PHASE_FRAMES > 1) ? $clog2(PHASE_FRAMES) : 1;

  localparam logic [XW-1:0]  X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(HEIGHT - 1);
  // The blank counter is loaded with HBLANK-1 and exits at zero, which gives
  // exactly HBLANK idle cycles.
  localparam logic [HCW-1:0] H_LOAD  = HCW'(HBLANK - 1);
  localparam logic [PFW-1:0] PF_LAST = PFW'(PHASE_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACTIVE    = 2'd1,
    S_HBLANK    = 2'd2,
    S_FRAME_END = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [HCW-1:0]   hcnt_q, hcnt_d;
  logic             stop_q, stop_d;
  logic [PFW-1:0]   pfc_q, pfc_d;
  logic [1:0]       phase_q, phase_d;
  logic [FCW-1:0]   frame_count_q, frame_count_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      hcnt_q        <= '0;
      stop_q        <= 1'b0;
      pfc_q         <= '0;
      phase_q       <= 2'd0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hcnt_q        <= hcnt_d;
      stop_q        <= stop_d;
      pfc_q         <= pfc_d;
      phase_q       <= phase_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    hcnt_d        = hcnt_q;
    stop_d        = stop_q;
    pfc_d         = pfc_q;
    phase_d       = phase_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        // A simultaneous stop is dropped here, so start always wins.
        if (start) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
        end
      end

      S_ACTIVE: begin
        if (stop) stop_d = 1'b1;
        if (ready) begin
          if (x_q != X_LAST) begin
            x_d = x_q + 1'b1;
          end else if (y_q != Y_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
            if (HBLANK > 0) begin
              state_d = S_HBLANK;
              hcnt_d  = H_LOAD;
            end
          end else begin
            // Coordinates are cleared now so the next frame starts at (0,0).
            x_d     = '0;
            y_d     = '0;
            state_d = S_FRAME_END;
          end
        end
      end

      S_HBLANK: begin
        if (stop) stop_d = 1'b1;
        if (hcnt_q == '0) state_d = S_ACTIVE;
        else              hcnt_d  = hcnt_q - 1'b1;
      end

      S_FRAME_END: begin
        frame_count_d = frame_count_q + 1'b1;
        if (pfc_q == PF_LAST) begin
          pfc_d   = '0;
          phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        end else begin
          pfc_d = pfc_q + 1'b1;
        end
        // A stop arriving in this very cycle still ends the stream here.
        if (stop_q || stop) state_d = S_IDLE;
        else                state_d = S_ACTIVE;
        stop_d = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign valid       = (state_q == S_ACTIVE);
  assign busy        = (state_q != S_IDLE);
  assign x           = x_q;
  assign y           = y_q;
  assign phase       = phase_q;
  assign frame_count = frame_count_q;
  assign sof         = valid && (x_q == '0) && (y_q == '0);
  assign eol         = valid && (x_q == X_LAST);
  assign eof         = eol && (y_q == Y_LAST);

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Controller that sequences the Pixel pipeline, frame by frame.
- Generates the raster coordinates and valid/sof/eol/eof markers for each pixel beat sent into the pipeline, and applies downstream back-pressure.
- Selects the active pipeline phase (INIT, CREATE_EDGE, ADD_NOISE). It rotates to the next phase after a fixed number of completed frames.
- Sits between the frame-level control (testbench or host) and the PipeLine input stage.

Parameters:
- WIDTH, 8, pixels per line (≥2).
- HEIGHT, 4, lines per frame (≥1).
- HBLANK, 2, idle cycles between lines (0 allowed; no blank after the last line).
- PHASE_FRAMES, 1, frames completed per phase before advancing (≥1).
- FCW, 16, frame_count width.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  level; begins streaming when sampled high in IDLE.
- stop  input  1  pulse/level; request to halt at the end of the current frame.
- ready  input  1  pipeline can accept a beat this cycle.
- valid  output  1  beat presented (x, y, markers valid).
- x  output  $clog2(WIDTH)  pixel column of the current beat.
- y  output  $clog2(HEIGHT) (min 1)  line of the current beat.
- sof  output  1  valid beat is x=0, y=0.
- eol  output  1  valid beat is x=WIDTH-1.
- eof  output  1  valid beat is x=WIDTH-1, y=HEIGHT-1.
- phase  output  2  0=INIT, 1=CREATE_EDGE, 2=ADD_NOISE; 3 is never driven.
- busy  output  1  state ≠ IDLE.
- frame_count  output  FCW  completed frames since reset; wraps modulo 2^FCW.

Behaviour:
- Reset (asynchronous, reset_n low) forces state IDLE. All outputs go to 0: valid, x, y, markers, phase=INIT, busy, frame_count. The stop latch and the phase frame counter also clear. Reset mid-frame abandons the frame with no completion side effects.
- States: IDLE, ACTIVE, HBLANK, FRAME_END.
- IDLE:
  - valid=0.
  - start=1 at a posedge → ACTIVE next cycle with x=0, y=0. Latency is 1 cycle from start sampled to the first valid.
- ACTIVE:
  - valid=1.
  - A transfer occurs when valid && ready. With ready=0, x, y and the markers hold stable (AXI-style; valid is never withdrawn).
  - On a transfer with x<WIDTH-1: x++.
  - On a transfer at x=WIDTH-1, y<HEIGHT-1: x←0, y++. Go to HBLANK if HBLANK>0, else stay ACTIVE.
  - On a transfer at x=WIDTH-1, y=HEIGHT-1: go to FRAME_END.
- HBLANK:
  - valid=0 for exactly HBLANK cycles via an internal counter, then → ACTIVE.
  - ready is ignored.
- FRAME_END (1 cycle, valid=0):
  - frame_count++.
  - Phase frame counter increments. When it reaches PHASE_FRAMES it clears and phase advances INIT→CREATE_EDGE→ADD_NOISE→INIT. phase changes only here, never mid-frame.
  - Next state is IDLE if stop is latched (the latch then clears), else ACTIVE with x=0, y=0.
- Frame period with ready held high: WIDTH·HEIGHT + (HEIGHT-1)·HBLANK + 1 cycles.
- stop:
  - Sampled any cycle in ACTIVE, HBLANK or FRAME_END, it is latched.
  - stop in the same cycle as the FRAME_END transition counts for that frame.
  - stop in IDLE is ignored.
- start while busy is ignored. start and stop both high in IDLE → start wins, and stop is not latched.
- Markers are combinational from x/y/state and qualified by valid (0 when valid=0).

Test Plan (WIDTH=4, HEIGHT=2, HBLANK=1, PHASE_FRAMES=2, FCW=16):
- Reset, then start pulse, ready=1 → valid rises 1 cycle after start. Beats (x,y): (0,0)sof,(1,0),(2,0),(3,0)eol, 1 blank, (0,1),(1,1),(2,1),(3,1)eol+eof, 1 FRAME_END. frame_count=1 at the 10th cycle after the first beat; phase stays 0.
- Continuous run, ready=1 → phase sequence per frame is 0,0,1,1,2,2,0. frame_count=6 after 60 cycles from the first beat; no gap beyond FRAME_END between frames.
- ready low for 3 cycles at beat (2,0) → valid stays 1, x=2/y=0 held for all 3 cycles. The frame completes 3 cycles later (13-cycle frame).
- stop pulse at beat (1,1) → the frame completes, valid=0 and busy=0 after FRAME_END, frame_count=1. A later start restarts at (0,0) with phase retained.
- reset_n low at beat (2,1) of frame 2 → all outputs 0 immediately (asynchronous). After release: idle, frame_count=0, phase=0.
- start and stop both high in IDLE → streaming starts and continues past frame 1 (stop not latched).
